debounce_3inputs: RTL and testbench
===================================

# debounce_3inputs

Debounces and synchronizes three raw, asynchronous button/switch inputs and presents clean levels `w`, `x`, `y` that feed the three-input AND gate stage directly downstream. Each channel has a two-flop synchronizer and a stability counter. A channel's output only takes a new level after the synchronized input has held that level for `STABLE_CYCLES` consecutive clocks. A one-cycle `changed` strobe flags any output update.

## Interface
- `STABLE_CYCLES`, default 4: consecutive clocks a new synchronized level must persist before the output adopts it. Legal range is 1..255.
- `CNT_W`, default 8: stability counter width. Must satisfy 2^CNT_W > STABLE_CYCLES.

- `clk`  input  1  single clock; all state updates on the rising edge
- `rst`  input  1  synchronous, active-high reset
- `btn_w`  input  1  raw asynchronous input, channel w
- `btn_x`  input  1  raw asynchronous input, channel x
- `btn_y`  input  1  raw asynchronous input, channel y
- `w`  output  1  debounced level, channel w (registered)
- `x`  output  1  debounced level, channel x (registered)
- `y`  output  1  debounced level, channel y (registered)
- `changed`  output  1  one-cycle pulse when any of w/x/y changed on this edge (registered)

## Operation
- The three channels are identical and fully independent. There is no shared counter.
- Per channel, sampled on every rising edge:
  - Synchronizer: `s1 <= btn`, then `s2 <= s1`.
  - If `s2 == out`: `cnt <= 0`.
  - Else if `cnt == STABLE_CYCLES-1`: `out <= s2` and `cnt <= 0`.
  - Else: `cnt <= cnt + 1`.
- Each channel is a two-state machine, IDLE (`cnt == 0`, `s2 == out`) and COUNTING (`s2 != out`).
  - A mismatch moves IDLE to COUNTING.
  - Any return of `s2` to `out` aborts to IDLE with the count discarded. Counts never accumulate across glitches.
- The counter never exceeds `STABLE_CYCLES-1`, so it cannot overflow or wrap.
- `changed <= (new w != old w) | (new x != old x) | (new y != old y)`, evaluated on the same edge as the updates. It is high for exactly one cycle per updating edge, even when several channels update on the same edge.
- Reset (`rst` high at an edge) forces `s1`, `s2`, `cnt`, `w`, `x`, `y` and `changed` to 0.
  - Reset takes priority over every other update.
  - Reset mid-count discards the pending transition.
  - After reset is released, an input held high is treated as a fresh transition and needs the full latency.

## Timing
- Reset values: `w=0`, `x=0`, `y=0`, `changed=0`.
- Latency: `btn` changes before edge k and then stays stable. The output updates at edge k+STABLE_CYCLES+1, i.e. STABLE_CYCLES+2 edges including edge k. `changed` is high during the cycle that follows that edge.
- Glitch rejection, counted in clock samples:
  - A level held for fewer than STABLE_CYCLES samples is ignored.
  - A level held for exactly STABLE_CYCLES samples is accepted.
- With STABLE_CYCLES=1, latency is 3 edges and there is no filtering beyond synchronization.
- Simultaneous changes on several channels with identical timing update on the same edge and produce a single `changed` pulse.
- Outputs are purely registered, with no combinational path from `btn_*` to any output.

## Test plan
- Reset: hold `rst=1` for 3 clocks with all `btn_*=1` -> `w=x=y=0` and `changed=0` throughout. Release with `btn_w=1` still held -> `w` rises on the 6th edge after release (STABLE_CYCLES=4).
- Clean press: `btn_x` goes 0->1 before edge 1 and stays high -> `x=1` after edge 6 with `changed=1` for one cycle. Release before edge 20 -> `x=0` after edge 25, with another one-cycle `changed`.
- Glitch: `btn_y` high for 3 samples then low -> `y` stays 0 and `changed` stays 0. Repeat with 4 samples high -> `y` pulses high for 4 cycles.
- Bounce: `btn_w` pattern 1,0,1,1,0,1,1,1,1 (one sample per clock) -> `w` rises only after the final run of four 1s. There is exactly one `changed` pulse.
- Concurrent channels: `btn_w`, `btn_x`, `btn_y` all go high before the same edge -> all three outputs rise on the same edge with a single one-cycle `changed`. The downstream AND output goes to 1 on that edge.
- Reset mid-count: `btn_x` goes high and `rst` is asserted on edge 4 -> `x` stays 0 and the counter clears. After release, `x` rises 6 edges later.

Source files
------------

// File: rtl/debounce_3inputs.sv
// debounce_3inputs
//   Synchronizes and debounces three raw asynchronous button/switch inputs.
//   Each channel has a two-flop synchronizer, a stability counter and a
//   two-state IDLE/COUNTING machine. A channel's output adopts a new level
//   only after the synchronized input has held it for STABLE_CYCLES clocks.
//   The debounced levels feed a downstream three-input AND stage.
//
// Parameters
//   STABLE_CYCLES : consecutive samples a new level must persist (1..255)
//   CNT_W         : stability counter width, 2**CNT_W > STABLE_CYCLES
//
// Ports
//   clk      : clock, all state updates on the rising edge
//   rst      : synchronous active-high reset
//   btn_w/x/y: raw asynchronous inputs
//   w/x/y    : registered debounced levels
//   changed  : registered one-cycle pulse when any of w/x/y updated
module debounce_3inputs #(
    parameter int unsigned STABLE_CYCLES = 4,
    parameter int unsigned CNT_W         = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_w,
    input  logic btn_x,
    input  logic btn_y,
    output logic w,
    output logic x,
    output logic y,
    output logic changed
);

    typedef enum logic {
        IDLE     = 1'b0,
        COUNTING = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

    logic [2:0]       btn;
    logic [2:0]       s1_q,  s1_d;
    logic [2:0]       s2_q,  s2_d;
    logic [2:0]       out_q, out_d;
    logic             changed_q, changed_d;
    logic [CNT_W-1:0] cnt_q   [3];
    logic [CNT_W-1:0] cnt_d   [3];
    state_t           state_q [3];
    state_t           state_d [3];

    assign btn = {btn_y, btn_x, btn_w};

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q      <= '0;
            s2_q      <= '0;
            out_q     <= '0;
            changed_q <= 1'b0;
            for (int unsigned i = 0; i < 3; i++) begin
                cnt_q[i]   <= '0;
                state_q[i] <= IDLE;
            end
        end else begin
            s1_q      <= s1_d;
            s2_q      <= s2_d;
            out_q     <= out_d;
            changed_q <= changed_d;
            for (int unsigned i = 0; i < 3; i++) begin
                cnt_q[i]   <= cnt_d[i];
                state_q[i] <= state_d[i];
            end
        end
    end

    // state_q always equals (s2_q != out_q): the next state is derived from
    // the value s2 will take (s1_q) against the output being registered on
    // the same edge, so the machine never lags the comparison it encodes.
    always_comb begin
        s1_d  = btn;
        s2_d  = s1_q;
        out_d = out_q;
        for (int unsigned i = 0; i < 3; i++) begin
            cnt_d[i]   = cnt_q[i];
            state_d[i] = state_q[i];
        end

        for (int unsigned i = 0; i < 3; i++) begin
            case (state_q[i])
                IDLE: begin
                    cnt_d[i] = '0;
                end
                COUNTING: begin
                    if (cnt_q[i] == CNT_LAST) begin
                        out_d[i] = s2_q[i];
                        cnt_d[i] = '0;
                    end else begin
                        cnt_d[i] = cnt_q[i] + CNT_W'(1);
                    end
                end
                default: begin
                    cnt_d[i] = '0;
                end
            endcase
            // A return of s2 to out drops back to IDLE and the count restarts.
            state_d[i] = (s1_q[i] != out_d[i]) ? COUNTING : IDLE;
        end

        changed_d = |(out_d ^ out_q);
    end

    assign w       = out_q[0];
    assign x       = out_q[1];
    assign y       = out_q[2];
    assign changed = changed_q;

endmodule

// File: tb/tb_debounce_3inputs.sv
module tb_debounce_3inputs;

    logic clk = 1'b0;
    logic rst;
    logic btn_w, btn_x, btn_y;
    logic w, x, y, changed;

    int pass_cnt = 0;
    int total    = 0;

    always #5 clk = ~clk;

    debounce_3inputs #(
        .STABLE_CYCLES(4),
        .CNT_W        (8)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .btn_w  (btn_w),
        .btn_x  (btn_x),
        .btn_y  (btn_y),
        .w      (w),
        .x      (x),
        .y      (y),
        .changed(changed)
    );

    typedef struct {
        logic rst;
        logic bw, bx, by;
        logic ew, ex, ey, ech;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic act, input logic exp);
        total++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %b expected %b", name, act, exp);
    endtask

    // Apply current inputs at one rising edge, settle, then sample.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic add(input logic r, input logic bw, input logic bx, input logic by,
                       input logic ew, input logic ex, input logic ey, input logic ech);
        vec_t v;
        v.rst = r; v.bw = bw; v.bx = bx; v.by = by;
        v.ew = ew; v.ex = ex; v.ey = ey; v.ech = ech;
        vecs.push_back(v);
    endtask

    task automatic do_reset();
        rst = 1'b1; btn_w = 1'b0; btn_x = 1'b0; btn_y = 1'b0;
        step();
        step();
        rst = 1'b0;
    endtask

    logic [8:0] bounce_pat;

    initial begin
        rst = 1'b1; btn_w = 1'b1; btn_x = 1'b1; btn_y = 1'b1;

        // Reset held with all buttons high, then w alone held high.
        for (int i = 0; i < 3; i++) add(1, 1, 1, 1, 0, 0, 0, 0);
        for (int i = 1; i <= 5; i++) add(0, 1, 0, 0, 0, 0, 0, 0);
        add(0, 1, 0, 0, 1, 0, 0, 1);
        add(0, 1, 0, 0, 1, 0, 0, 0);
        // Reset, then all three channels rise together.
        add(1, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 1; i <= 5; i++) add(0, 1, 1, 1, 0, 0, 0, 0);
        add(0, 1, 1, 1, 1, 1, 1, 1);
        add(0, 1, 1, 1, 1, 1, 1, 0);
        add(1, 0, 0, 0, 0, 0, 0, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            rst = vecs[i].rst; btn_w = vecs[i].bw; btn_x = vecs[i].bx; btn_y = vecs[i].by;
            step();
            check($sformatf("vec%0d_w", i), w, vecs[i].ew);
            check($sformatf("vec%0d_x", i), x, vecs[i].ex);
            check($sformatf("vec%0d_y", i), y, vecs[i].ey);
            check($sformatf("vec%0d_changed", i), changed, vecs[i].ech);
            check($sformatf("vec%0d_and", i), w & x & y, vecs[i].ew & vecs[i].ex & vecs[i].ey);
        end

        // Clean press and release on x: high before edges 1..19.
        do_reset();
        for (int e = 1; e <= 30; e++) begin
            btn_x = (e < 20);
            step();
            check($sformatf("press_e%0d_x", e), x, (e >= 6 && e < 25));
            check($sformatf("press_e%0d_changed", e), changed, (e == 6 || e == 25));
        end

        // Glitch of 3 samples on y is rejected.
        do_reset();
        for (int e = 1; e <= 12; e++) begin
            btn_y = (e <= 3);
            step();
            check($sformatf("glitch3_e%0d_y", e), y, 1'b0);
            check($sformatf("glitch3_e%0d_changed", e), changed, 1'b0);
        end

        // Exactly 4 samples on y is accepted: y high after edges 6..9.
        do_reset();
        for (int e = 1; e <= 14; e++) begin
            btn_y = (e <= 4);
            step();
            check($sformatf("pulse4_e%0d_y", e), y, (e >= 6 && e <= 9));
            check($sformatf("pulse4_e%0d_changed", e), changed, (e == 6 || e == 10));
        end

        // Bounce 1,0,1,1,0,1,1,1,1 on w: only the final run of four 1s counts.
        do_reset();
        bounce_pat = 9'b111101101;
        for (int e = 1; e <= 16; e++) begin
            btn_w = (e <= 9) ? bounce_pat[e-1] : 1'b1;
            step();
            check($sformatf("bounce_e%0d_w", e), w, (e >= 11));
            check($sformatf("bounce_e%0d_changed", e), changed, (e == 11));
        end

        // Reset on edge 4 mid-count discards the pending x transition.
        do_reset();
        for (int e = 1; e <= 13; e++) begin
            btn_x = 1'b1;
            rst   = (e == 4);
            step();
            check($sformatf("rstmid_e%0d_x", e), x, (e >= 10));
            check($sformatf("rstmid_e%0d_changed", e), changed, (e == 10));
        end

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
